// File: rtl/serdes_pkg.sv
// Shared serdes definitions: header field layout, depacketizer FSM encoding, clog2.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serdes_pkg;

    localparam int HDR_START_BIT = 0;
    localparam int HDR_ID_BIT    = 1;
    localparam int HDR_CNT_BASE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/payload_fifo.sv
// Single-clock first-word-fall-through buffer for reassembled payloads.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: pops on an empty buffer are ignored; push+pop on one edge keeps the count.
module payload_fifo
    import serdes_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk_payload,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             pop_eff;
    logic             push_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_eff  = pop_rdy && (cnt_q != '0);
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign push_eff = push_vld && ((cnt_q != CNT_W'(DEPTH)) || pop_eff);

    always_ff @(posedge clk_payload or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_eff) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_eff)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_eff, pop_eff})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_payload) begin
        if (push_eff) mem[wr_ptr] <= push_dat;
    end

    assign head_vld = (cnt_q != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt_q;

endmodule

// File: rtl/depacketizer.sv
// Reassembles header-prefixed streams of link packets into payload words and buffers them.
// Latency: payload at the buffer head one cycle after its final data packet is accepted.
// Backpressure: packet_ready_o gates new headers; payload leaves only on payload_grant_i.
module depacketizer
    import serdes_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 128,
    parameter int PACKET_WIDTH  = 16,
    parameter bit ID            = 1'b0,
    parameter int N_PKTS_BITS   = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk_payload,
    input  logic                     reset,
    input  logic                     packet_valid_i,
    input  logic [PACKET_WIDTH-1:0]  packet_i,
    output logic                     packet_ready_o,
    output logic                     packet_received_o,
    output logic                     error_o,
    output logic                     payload_valid_o,
    output logic [PAYLOAD_WIDTH-1:0] payload_o,
    input  logic                     payload_grant_i
);

    localparam int N_PKTS = PAYLOAD_WIDTH / PACKET_WIDTH;
    localparam int CNT_W  = clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;
    localparam int ASM_W  = PAYLOAD_WIDTH - PACKET_WIDTH;

    state_t                 state_q, state_nxt;
    logic [N_PKTS_BITS-1:0] cnt_q, cnt_nxt;
    logic                   res_q, res_nxt;
    logic                   rcv_q, rcv_nxt;
    logic                   err_q, err_nxt;
    logic                   rdy_q, rdy_nxt;
    logic                   push;
    logic                   shift_en;
    logic                   pop_eff;
    logic [OCC_W-1:0]       occ_nxt;
    logic [CNT_W-1:0]       fifo_count;
    logic [ASM_W-1:0]       assembly_q;

    logic                   hdr_start;
    logic                   hdr_id;
    logic [N_PKTS_BITS-1:0] hdr_n;

    assign hdr_start = packet_i[HDR_START_BIT];
    assign hdr_id    = packet_i[HDR_ID_BIT];
    assign hdr_n     = packet_i[HDR_CNT_BASE +: N_PKTS_BITS];
    assign pop_eff   = payload_grant_i && payload_valid_o;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        res_nxt   = res_q;
        rcv_nxt   = 1'b0;
        err_nxt   = 1'b0;
        push      = 1'b0;
        shift_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (packet_valid_i && hdr_start) begin
                    if (hdr_id == ID && hdr_n == N_PKTS_BITS'(N_PKTS) && rdy_q) begin
                        cnt_nxt   = N_PKTS_BITS'(N_PKTS);
                        res_nxt   = 1'b1;
                        state_nxt = ST_COLLECT;
                    end else begin
                        err_nxt   = 1'b1;
                        cnt_nxt   = hdr_n;
                        state_nxt = (hdr_n != '0) ? ST_DISCARD : ST_IDLE;
                    end
                end
            end
            ST_COLLECT: begin
                if (packet_valid_i) begin
                    shift_en = 1'b1;
                    cnt_nxt  = cnt_q - N_PKTS_BITS'(1);
                    if (cnt_q == N_PKTS_BITS'(1)) begin
                        push      = 1'b1;
                        res_nxt   = 1'b0;
                        rcv_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (packet_valid_i) begin
                    cnt_nxt = cnt_q - N_PKTS_BITS'(1);
                    if (cnt_q == N_PKTS_BITS'(1)) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Ready reflects the buffer occupancy the FSM will see next cycle, reservation included.
        occ_nxt = OCC_W'(fifo_count) + OCC_W'(push) + OCC_W'(res_nxt) - OCC_W'(pop_eff);
        rdy_nxt = (state_nxt == ST_IDLE) && (occ_nxt < OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk_payload or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= 1'b0;
            rcv_q   <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            res_q   <= res_nxt;
            rcv_q   <= rcv_nxt;
            err_q   <= err_nxt;
            rdy_q   <= rdy_nxt;
        end
    end

    // Packets shift in from the top so the first one ends up in the lowest slot.
    always_ff @(posedge clk_payload) begin
        if (shift_en) assembly_q <= {packet_i, assembly_q[ASM_W-1:PACKET_WIDTH]};
    end

    payload_fifo #(
        .WIDTH (PAYLOAD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_payload_fifo (
        .clk_payload (clk_payload),
        .reset       (reset),
        .push_vld    (push),
        .push_dat    ({packet_i, assembly_q}),
        .pop_rdy     (payload_grant_i),
        .head_vld    (payload_valid_o),
        .head_dat    (payload_o),
        .count       (fifo_count)
    );

    assign packet_ready_o    = rdy_q;
    assign packet_received_o = rcv_q;
    assign error_o           = err_q;

endmodule

// File: doc/depacketizer.md
DEPACKETIZER -- requirements
Module: depacketizer

Interface
REQ-001 Parameters SHALL be:
- PAYLOAD_WIDTH, 128, reassembled payload width.
- PACKET_WIDTH, 16, link packet width.
- ID, 0, 1-bit stream identifier accepted by this instance.
- N_PKTS_BITS, 4, header packet-count field width.
- FIFO_DEPTH, 2, payload buffer entries.
REQ-002 Ports SHALL be:
- clk_payload  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- packet_valid_i  in  1  packet_i holds a packet this cycle.
- packet_i  in  PACKET_WIDTH  header or data packet.
- packet_ready_o  out  1  a new header may be sent.
- packet_received_o  out  1  one-cycle pulse per payload completed and buffered.
- error_o  out  1  one-cycle pulse per dropped stream.
- payload_valid_o  out  1  FIFO head valid.
- payload_o  out  PAYLOAD_WIDTH  FIFO head (first-word fall-through).
- payload_grant_i  in  1  consumer takes the head this cycle.

Function
REQ-003 N_PKTS SHALL equal PAYLOAD_WIDTH/PACKET_WIDTH; the header SHALL be: bit0=1 start flag, bit1=id, bits[N_PKTS_BITS+1:2]=n_pkts, all other bits ignored.
REQ-004 FSM states SHALL be IDLE, COLLECT and DISCARD; on reset the FSM SHALL be in IDLE.
REQ-005 In IDLE, a valid packet with bit0=0 SHALL be ignored without error.
REQ-006 In IDLE, a valid header with id==ID, n_pkts==N_PKTS and packet_ready_o=1 SHALL:
- load the counter with N_PKTS;
- reserve one FIFO entry;
- go to COLLECT.
REQ-007 In IDLE, any other valid header SHALL pulse error_o next cycle, load the counter with the header n_pkts and go to DISCARD; if n_pkts==0 it SHALL stay in IDLE.
REQ-008 In COLLECT, each valid packet SHALL be data: the k-th packet (k=0..N_PKTS-1) is written to assembly bits [k*PACKET_WIDTH +: PACKET_WIDTH] and the counter decrements.
REQ-009 Invalid cycles in COLLECT or DISCARD SHALL hold all state; gaps are legal.
REQ-010 When the final data packet is accepted in COLLECT:
- the assembled payload SHALL be pushed into the FIFO on that edge;
- the reservation SHALL be released;
- packet_received_o SHALL pulse the following cycle;
- the FSM SHALL return to IDLE.
REQ-011 In DISCARD, valid packets SHALL decrement the counter without being stored; at zero the FSM SHALL return to IDLE; no FIFO push and no packet_received_o.
REQ-012 packet_ready_o SHALL be registered and SHALL be 1 only when in IDLE and (FIFO count + reservation) < FIFO_DEPTH.
REQ-013 Latency: final data packet accepted at edge t with the FIFO empty SHALL give payload_valid_o=1 and payload_o valid in the cycle after t.
REQ-014 payload_grant_i while payload_valid_o=0 SHALL be ignored.
REQ-015 A push and a pop on the same edge SHALL both take effect with the count unchanged, including when the FIFO is full.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count width SHALL be clog2(FIFO_DEPTH+1).

Reset
REQ-017 Reset SHALL asynchronously set:
- FSM to IDLE;
- counter, reservation, FIFO pointers and count to 0;
- packet_received_o, error_o and payload_valid_o to 0;
- packet_ready_o to 1.
REQ-018 Reset during COLLECT SHALL discard the partial payload; packets arriving after reset deasserts SHALL be parsed from IDLE.
REQ-019 Assembly and FIFO data storage need not be reset; payload_o is don't-care while payload_valid_o=0.

Structure
REQ-020 The shared serdes package SHALL hold:
- header field offsets (start bit 0, id bit 1, count base 2);
- FSM state encoding;
- the clog2 function, shared with the transmit side.
REQ-021 The payload buffer SHALL be one sub-module, payload_fifo: single clock, FWFT, parameterised by width and depth.

Verification
All scenarios use defaults: N_PKTS=8, so the good header is 0x0021.
REQ-022 Send header 0x0021, then data 0x0001..0x0008 back-to-back -> packet_received_o pulses once; payload_o=0x0008_0007_0006_0005_0004_0003_0002_0001 one cycle after the last packet.
REQ-023 Repeat REQ-022 with a 3-cycle valid gap after the 4th packet -> identical payload, completion delayed 3 cycles, error_o=0.
REQ-024 Send header 0x0023 (id=1), then 8 data packets, then a good stream -> error_o pulses once, no push for the first stream, the second payload is delivered correctly.
REQ-025 Hold payload_grant_i=0 and send two good streams -> packet_ready_o=0 after the second header; grant once -> packet_ready_o=1 the next cycle, first payload popped, second payload becomes the head.
REQ-026 Assert reset after the 5th data packet, then send a full good stream -> exactly one payload equal to the new stream's data, no stale data.
